// File: rtl/cook_program_sequencer.sv
// cook_program_sequencer: multi-stage microwave cook program controller.
// Loads each non-empty stage's BCD time into the countdown timer one nibble
// per clock, runs it while duty-cycling the magnetron by stage power, and
// advances on timer_zero.
// Optional: define COOK_BEEP_EN to add the `beep` output. The beep rises the
// clock after `done` and lasts for 3 tick_1hz pulses.
module cook_program_sequencer #(
  parameter int NUM_STAGES   = 2,
  parameter int POWER_PERIOD = 10
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       tick_1hz,
  input  logic       cfg_we,
  input  logic [1:0] cfg_stage,
  input  logic [3:0] cfg_min,
  input  logic [3:0] cfg_sec_tens,
  input  logic [3:0] cfg_sec_ones,
  input  logic [3:0] cfg_power,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic [1:0] stage_idx,
  output logic       busy,
  output logic       done
`ifdef COOK_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int          SW   = 2;
  localparam int unsigned MAXS = 4;
  localparam int unsigned NS   = NUM_STAGES;
  localparam int          CW   = (POWER_PERIOD > 15) ? $clog2(POWER_PERIOD + 1) : 4;
  localparam logic [CW-1:0] PP      = CW'(POWER_PERIOD);
  localparam logic [CW-1:0] PP_LAST = CW'(POWER_PERIOD - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    lcnt_q, lcnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [3:0]    data_q, data_d;
  logic          loadn_q, enable_q, mag_q, busy_q, done_q, done_d;

  // Storage is sized for the 4 addressable stages; unused entries stay 0:00
  // and are therefore always skipped as empty.
  logic [3:0]    min_q  [MAXS];
  logic [3:0]    tens_q [MAXS];
  logic [3:0]    ones_q [MAXS];
  logic [CW-1:0] pwr_q  [MAXS];

  logic [MAXS-1:0] live;
  logic            first_found, later_found;
  logic [SW-1:0]   first_idx, later_idx;
  logic [CW-1:0]   cfg_pwr_ext, cfg_pwr_clamped;
  logic            go;

  assign cfg_pwr_ext     = CW'(cfg_power);
  assign cfg_pwr_clamped = (cfg_pwr_ext > PP) ? PP : cfg_pwr_ext;
  assign go              = start && !stop && door_closed;

  // Locate the first non-empty stage and the next non-empty stage above the current one.
  always_comb begin
    live        = '0;
    first_found = 1'b0;
    first_idx   = '0;
    later_found = 1'b0;
    later_idx   = '0;
    for (int unsigned i = 0; i < MAXS; i++) begin
      live[i] = |{min_q[i], tens_q[i], ones_q[i]};
      if (live[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = SW'(i);
      end
      if (live[i] && !later_found && (SW'(i) > stage_q)) begin
        later_found = 1'b1;
        later_idx   = SW'(i);
      end
    end
  end

  // Next-state, stage selection, duty counter and load digit selection.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    stage_d = stage_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (first_found) begin
            stage_d = first_idx;
            lcnt_d  = '0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (lcnt_q == 2'd2) state_d = S_ARM;
        else                lcnt_d  = lcnt_q + 2'd1;
      end
      S_ARM: begin
        duty_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (tick_1hz) duty_d = (duty_q >= PP_LAST) ? '0 : duty_q + 1'b1;
        if (stop || !door_closed) state_d = S_PAUSE;
        else if (timer_zero)      state_d = S_NEXT;
      end
      S_PAUSE: begin
        if (stop) begin
          stage_d = '0;
          state_d = S_IDLE;
        end else if (go) begin
          state_d = S_RUN;
        end
      end
      S_NEXT: begin
        if (later_found) begin
          stage_d = later_idx;
          lcnt_d  = '0;
          state_d = S_LOAD;
        end else begin
          done_d  = 1'b1;
          stage_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from next-state values so they line up with the state they describe.
    if (state_d == S_LOAD) begin
      case (lcnt_d)
        2'd0:    data_d = min_q[stage_d];
        2'd1:    data_d = tens_q[stage_d];
        default: data_d = ones_q[stage_d];
      endcase
    end
  end

  // Sequencer state and registered timer/magnetron outputs.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q  <= S_IDLE;
      lcnt_q   <= '0;
      stage_q  <= '0;
      duty_q   <= '0;
      data_q   <= '0;
      loadn_q  <= 1'b1;
      enable_q <= 1'b0;
      mag_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      stage_q  <= stage_d;
      duty_q   <= duty_d;
      data_q   <= data_d;
      loadn_q  <= (state_d != S_LOAD);
      enable_q <= (state_d == S_RUN);
      mag_q    <= (state_d == S_RUN) && (duty_d < pwr_q[stage_d]);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  // Stage configuration store, writable only while idle.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      for (int unsigned i = 0; i < MAXS; i++) begin
        min_q[i]  <= '0;
        tens_q[i] <= '0;
        ones_q[i] <= '0;
        pwr_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAXS; i++) begin
        if ((state_q == S_IDLE) && cfg_we && (cfg_stage == SW'(i)) && (i < NS)) begin
          min_q[i]  <= cfg_min;
          tens_q[i] <= cfg_sec_tens;
          ones_q[i] <= cfg_sec_ones;
          pwr_q[i]  <= cfg_pwr_clamped;
        end
      end
    end
  end

  assign timer_data   = data_q;
  assign timer_loadn  = loadn_q;
  assign timer_enable = enable_q;
  assign mag_on       = mag_q;
  assign stage_idx    = stage_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef COOK_BEEP_EN
  logic       beep_q;
  logic [1:0] beep_cnt_q;

  // Completion beep: rises after done, drops after 3 seconds or on a start press.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if (done_q) begin
      beep_q     <= 1'b1;
      beep_cnt_q <= '0;
    end else if (beep_q && start) begin
      beep_q <= 1'b0;
    end else if (beep_q && tick_1hz) begin
      if (beep_cnt_q == 2'd2) beep_q <= 1'b0;
      beep_cnt_q <= beep_cnt_q + 2'd1;
    end
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_cook_program_sequencer.sv
// Directed bench for cook_program_sequencer with a behavioural countdown timer.
module tb_cook_program_sequencer;

  logic       clock = 1'b0;
  logic       clearn, tick_1hz, cfg_we;
  logic [1:0] cfg_stage;
  logic [3:0] cfg_min, cfg_sec_tens, cfg_sec_ones, cfg_power;
  logic       start, stop, door_closed, timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn, timer_enable, mag_on, busy, done;
  logic [1:0] stage_idx;
`ifdef COOK_BEEP_EN
  logic       beep;
`endif

  cook_program_sequencer #(.NUM_STAGES(2), .POWER_PERIOD(10)) dut (
    .clock(clock), .clearn(clearn), .tick_1hz(tick_1hz),
    .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_min(cfg_min),
    .cfg_sec_tens(cfg_sec_tens), .cfg_sec_ones(cfg_sec_ones), .cfg_power(cfg_power),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_data(timer_data), .timer_loadn(timer_loadn), .timer_enable(timer_enable),
    .mag_on(mag_on), .stage_idx(stage_idx), .busy(busy), .done(done)
`ifdef COOK_BEEP_EN
    , .beep(beep)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Timer model and monitors
  int          tdiv = 0;
  logic [11:0] tsh;
  int          tcnt;
  int          digits[$];
  int          loads, on_secs, run_ticks, done_cnt;
  logic [31:0] pat;

  task automatic step();
    logic       shift, dec;
    logic [3:0] d;
    tick_1hz = (tdiv == 7);
    shift = !timer_loadn;
    d     = timer_data;
    dec   = tick_1hz && timer_enable;
    if (shift) begin digits.push_back(int'(d)); loads++; end
    if (dec) begin
      if (mag_on) begin on_secs++; pat[run_ticks] = 1'b1; end
      run_ticks++;
    end
    if (done) done_cnt++;
    @(posedge clock); #1;
    tdiv = (tdiv == 7) ? 0 : tdiv + 1;
    if (shift) begin
      tsh  = {tsh[7:0], d};
      tcnt = int'(tsh[11:8]) * 60 + int'(tsh[7:4]) * 10 + int'(tsh[3:0]);
    end
    if (dec && tcnt > 0) tcnt--;
    timer_zero = (tcnt == 0);
    tick_1hz = 1'b0;
  endtask

  task automatic clear_mon();
    digits.delete();
    loads = 0; on_secs = 0; run_ticks = 0; done_cnt = 0; pat = '0;
  endtask

  task automatic do_reset();
    clearn = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
    cfg_stage = '0; cfg_min = '0; cfg_sec_tens = '0; cfg_sec_ones = '0; cfg_power = '0;
    step(); step();
    clearn = 1'b1;
    tsh = '0; tcnt = 0; timer_zero = 1'b1;
    clear_mon();
  endtask

  task automatic cfg(input logic [1:0] s, input logic [3:0] m, input logic [3:0] t,
                     input logic [3:0] o, input logic [3:0] p);
    cfg_we = 1'b1; cfg_stage = s; cfg_min = m; cfg_sec_tens = t; cfg_sec_ones = o; cfg_power = p;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    repeat (3) step();
  endtask

  task automatic wait_ticks(input int n, input string tag);
    for (int k = 0; k < 3000 && run_ticks < n; k++) step();
    chk({tag, "_ticks_reached"}, 32'(run_ticks >= n), 1);
  endtask

  initial begin
    tick_1hz = 1'b0; timer_zero = 1'b1;
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loadn", timer_loadn, 1);
    chk("rst_enable", timer_enable, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_stage", stage_idx, 0);
    chk("rst_data", timer_data, 0);

    // 1: single 0:05 stage at full power
    cfg(0, 0, 0, 5, 10);
    press_start();
    chk("t1_busy_up", busy, 1);
    wait_done("t1");
    chk("t1_loads", loads, 3);
    chk("t1_d0", digits[0], 0);
    chk("t1_d1", digits[1], 0);
    chk("t1_d2", digits[2], 5);
    chk("t1_ticks", run_ticks, 5);
    chk("t1_on", on_secs, 5);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_busy_low", busy, 0);

    // 2: 0:10 at power 3 -> on for the first 3 seconds of the window
    do_reset();
    cfg(0, 0, 1, 0, 3);
    press_start();
    wait_done("t2");
    chk("t2_ticks", run_ticks, 10);
    chk("t2_on", on_secs, 3);
    chk("t2_pattern", pat, 32'h0000_0007);

    // 3: two stages, second is a power-0 stand time
    do_reset();
    cfg(0, 0, 0, 3, 10);
    cfg(1, 0, 0, 2, 0);
    press_start();
    wait_done("t3");
    chk("t3_loads", loads, 6);
    chk("t3_d3", digits[3], 0);
    chk("t3_d4", digits[4], 0);
    chk("t3_d5", digits[5], 2);
    chk("t3_ticks", run_ticks, 5);
    chk("t3_pattern", pat, 32'h0000_0007);
    chk("t3_done_once", done_cnt, 1);

    // 4a: door opens mid-run, resume keeps duty phase
    do_reset();
    cfg(0, 0, 0, 5, 3);
    press_start();
    wait_ticks(2, "t4a");
    step(); step();
    door_closed = 1'b0;
    step();
    chk("t4_pause_mag", mag_on, 0);
    chk("t4_pause_en", timer_enable, 0);
    chk("t4_pause_busy", busy, 1);
    repeat (20) step();
    chk("t4_pause_frozen", run_ticks, 2);
    door_closed = 1'b1;
    press_start();
    wait_done("t4a");
    chk("t4_ticks", run_ticks, 5);
    chk("t4_pattern", pat, 32'h0000_0007);

    // 4b: stop from pause in stage 1 cancels to idle with stage 0
    do_reset();
    cfg(0, 0, 0, 2, 10);
    cfg(1, 0, 0, 3, 10);
    press_start();
    for (int k = 0; k < 3000 && stage_idx != 2'd1; k++) step();
    chk("t4b_stage1", stage_idx, 1);
    wait_ticks(3, "t4b");
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4b_pause_busy", busy, 1);
    chk("t4b_pause_mag", mag_on, 0);
    chk("t4b_pause_stage", stage_idx, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4b_cancel_busy", busy, 0);
    chk("t4b_cancel_stage", stage_idx, 0);
    repeat (3) step();
    chk("t4b_no_done", done_cnt, 0);

    // 5: start+stop together, door open, all stages empty
    do_reset();
    cfg(0, 0, 0, 5, 10);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk("t5_startstop_busy", busy, 0);
    chk("t5_startstop_loads", loads, 0);
    door_closed = 1'b0;
    press_start();
    repeat (3) step();
    chk("t5_door_busy", busy, 0);
    door_closed = 1'b1;
    do_reset();
    press_start();
    repeat (4) step();
    chk("t5_empty_done", done_cnt, 1);
    chk("t5_empty_loads", loads, 0);
    chk("t5_empty_busy", busy, 0);

    // 6: cfg_we during RUN ignored; reset mid-run clears everything
    do_reset();
    cfg(0, 0, 0, 5, 10);
    press_start();
    wait_ticks(1, "t6");
    cfg(0, 0, 9, 9, 0);
    wait_done("t6");
    chk("t6_ticks", run_ticks, 5);
    chk("t6_on", on_secs, 5);
    clear_mon();
    press_start();
    wait_ticks(2, "t6b");
    step(); step();
    chk("t6_mag_before", mag_on, 1);
    clearn = 1'b0; step();
    chk("t6_rst_mag", mag_on, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_en", timer_enable, 0);
    clearn = 1'b1;
    clear_mon();
    press_start();
    repeat (4) step();
    chk("t6_empty_done", done_cnt, 1);
    chk("t6_empty_loads", loads, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cook_program_sequencer.md
Name: cook_program_sequencer

Overview:
Multi-stage cook program controller for the microwave oven. It holds NUM_STAGES programmed stages, each with a BCD time and a power level. It loads each stage's time into the countdown timer through the timer's nibble-serial load interface. It then runs the timer and duty-cycles the magnetron per the stage power level, and advances stages on timer_zero. It sits between the keypad/control front end and the existing timer and magnetron-control datapath.

Parameters:
NUM_STAGES, 2, number of programmable stages (1..4); stage index width SW = 2.
POWER_PERIOD, 10, duty window length in tick_1hz periods; power level p gives p on-seconds per window.

Ports:
clock  in  1  system clock (100 Hz domain)
clearn  in  1  synchronous active-low reset
tick_1hz  in  1  one-clock-wide pulse, once per second
cfg_we  in  1  write stage config; honoured only in IDLE
cfg_stage  in  2  stage index to write; values >= NUM_STAGES ignored
cfg_min  in  4  BCD minutes
cfg_sec_tens  in  4  BCD seconds tens (0..5)
cfg_sec_ones  in  4  BCD seconds ones
cfg_power  in  4  power level 0..15, clamped to POWER_PERIOD
start  in  1  start/resume request, level sampled each clock
stop  in  1  pause/cancel request, level sampled each clock
door_closed  in  1  1 = door closed
timer_zero  in  1  timer reads 0:00
timer_data  out  4  BCD digit to shift into timer
timer_loadn  out  1  active-low digit load strobe to timer
timer_enable  out  1  timer countdown enable
mag_on  out  1  magnetron drive
stage_idx  out  2  current stage
busy  out  1  high in every state except IDLE
done  out  1  one-clock pulse on program completion

Behaviour:
- Reset (clearn=0 at clock edge): state IDLE; all stage registers cleared to 0:00 power 0; timer_data=0, timer_loadn=1, timer_enable=0, mag_on=0, stage_idx=0, busy=0, done=0; duty counter 0. Reset mid-operation aborts immediately and drives mag_on=0 on the same edge.
- Stage is "empty" if min=sec_tens=sec_ones=0. Empty stages are skipped.
- IDLE: cfg_we writes the addressed stage. start=1 && stop=0 && door_closed=1: stage_idx <= first non-empty stage, go LOAD. If all stages are empty, pulse done and stay IDLE. start with door open is ignored.
- LOAD: 3 clocks, timer_loadn=0 each clock. timer_data = min, then sec_tens, then sec_ones; the timer shifts digits in. Then go ARM with timer_loadn=1.
- ARM: 1 clock for timer_zero to reflect the new value; duty counter <= 0; go RUN.
- RUN: timer_enable=1. mag_on = (duty_cnt < clamped power). duty_cnt increments on tick_1hz and wraps POWER_PERIOD-1 -> 0. Power 0 gives a stand time: the timer runs with mag off. Power >= POWER_PERIOD gives a continuous on.
- RUN -> PAUSE on stop=1 or door_closed=0, checked in that priority. This has priority over timer_zero in the same clock.
- RUN -> NEXT on timer_zero=1.
- PAUSE: timer_enable=0, mag_on=0; duty_cnt held. stop=1 -> IDLE (cancel; stage_idx <= 0). start=1 && stop=0 && door_closed=1 -> RUN, resuming with duty_cnt preserved.
- NEXT (1 clock): if a higher non-empty stage exists, set stage_idx to it and go LOAD. Otherwise pulse done, stage_idx <= 0, go IDLE.
- stop and start asserted together: stop wins in every state.
- mag_on and timer_enable are registered; both are 0 in every state except RUN.
- cfg_we outside IDLE has no effect.

Optional Feature:
Macro COOK_BEEP_EN.
- Defined: extra output beep (1 bit, reset 0). beep asserts the clock after done and stays high for 3 tick_1hz pulses. A start while beep is high clears it and is otherwise processed normally.
- Undefined: no beep port and no beep logic.

Test Plan:
1. Stage0 = 0:05 power 10, stage1 empty, start -> timer_loadn low 3 clocks carrying 0,0,5. mag_on is high during all 5 s. done pulses once after timer_zero; busy falls.
2. Stage0 = 0:10 power 3 -> mag_on high for ticks 0-2 and low for 3-9 of the window, 3 on-seconds total.
3. Stage0 = 0:03 power 10, stage1 = 0:02 power 0 -> second LOAD sends 0,0,2. Stage 1 runs with timer_enable=1 and mag_on=0 for 2 s, then done.
4. Door opens at 2 s into RUN -> mag_on=0 and timer_enable=0 next clock. Close the door plus start -> resume with the duty phase preserved. Stop in PAUSE -> IDLE and stage_idx=0.
5. start=stop=1 in IDLE -> stays IDLE. All stages empty plus start -> single done pulse and no load strobes.
6. clearn=0 mid-RUN -> the next edge gives mag_on=0, busy=0, and all stages read as empty. cfg_we during RUN leaves the stored config unchanged.
